// File: rtl/pipe_skid_chain.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pipe_skid_chain : chain of registered valid/ready skid stages with flush
//                   and occupancy count; every output and in_ready is a flop.
// Revision        : 1.0
// ----------------------------------------------------------------------------

// One main/skid pair; the skid catches the beat that arrives in the cycle
// after downstream stalls, so the upstream ready can come straight from a flop.
module pipe_skid_stage #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic              up_valid_i,
  output logic              up_ready_o,
  input  logic [DATA_W-1:0] up_data_i,
  output logic              dn_valid_o,
  input  logic              dn_ready_i,
  output logic [DATA_W-1:0] dn_data_o
);

  logic              m_v_q, m_v_d;
  logic              s_v_q, s_v_d;
  logic              rdy_q;
  logic [DATA_W-1:0] m_d_q, m_d_d;
  logic [DATA_W-1:0] s_d_q, s_d_d;
  logic              w_acc;
  logic              w_leave;

  assign w_acc   = up_valid_i & rdy_q;
  assign w_leave = m_v_q & dn_ready_i;

  // rdy_q mirrors ~s_v_q, so an accept never coincides with a full skid.
  always_comb begin
    m_v_d = m_v_q;
    s_v_d = s_v_q;
    m_d_d = m_d_q;
    s_d_d = s_d_q;
    if (w_leave) begin
      if (s_v_q) begin
        m_d_d = s_d_q;
        s_v_d = 1'b0;
      end else if (w_acc) begin
        m_d_d = up_data_i;
      end else begin
        m_v_d = 1'b0;
      end
    end else if (w_acc) begin
      if (!m_v_q) begin
        m_v_d = 1'b1;
        m_d_d = up_data_i;
      end else begin
        s_v_d = 1'b1;
        s_d_d = up_data_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m_v_q <= 1'b0;
      s_v_q <= 1'b0;
      rdy_q <= 1'b0;
    end else if (flush_i) begin
      m_v_q <= 1'b0;
      s_v_q <= 1'b0;
      rdy_q <= 1'b1;
    end else begin
      m_v_q <= m_v_d;
      s_v_q <= s_v_d;
      rdy_q <= ~s_v_d;
    end
  end

  // Payload registers carry no reset; their contents only matter under a valid flag.
  always_ff @(posedge clk) begin
    m_d_q <= m_d_d;
    s_d_q <= s_d_d;
  end

  assign up_ready_o = rdy_q;
  assign dn_valid_o = m_v_q;
  assign dn_data_o  = m_d_q;

endmodule

module pipe_skid_chain #(
  parameter  int DATA_W = 8,
  parameter  int STAGES = 2,
  localparam int CNT_W  = $clog2(2*STAGES+1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  occupancy
);

  logic              w_vld [STAGES+1];
  logic              w_rdy [STAGES+1];
  logic [DATA_W-1:0] w_dat [STAGES+1];

  assign w_vld[0]      = in_valid;
  assign w_dat[0]      = in_data;
  assign w_rdy[STAGES] = out_ready;

  generate
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
      pipe_skid_stage #(
        .DATA_W (DATA_W)
      ) u_stage (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush_i    (flush),
        .up_valid_i (w_vld[k]),
        .up_ready_o (w_rdy[k]),
        .up_data_i  (w_dat[k]),
        .dn_valid_o (w_vld[k+1]),
        .dn_ready_i (w_rdy[k+1]),
        .dn_data_o  (w_dat[k+1])
      );
    end
  endgenerate

  assign in_ready  = w_rdy[0];
  assign out_valid = w_vld[STAGES];
  assign out_data  = w_dat[STAGES];

  // Occupancy tracks the boundary handshakes, which equals the number of set valid flags.
  logic             w_in_fire;
  logic             w_out_fire;
  logic [CNT_W-1:0] occ_q, occ_d;

  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = out_valid & out_ready;

  always_comb begin
    occ_d = occ_q + CNT_W'(w_in_fire) - CNT_W'(w_out_fire);
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign occupancy = occ_q;

endmodule

`default_nettype wire

// File: tb/tb_pipe_skid_chain.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_pipe_skid_chain : randomized + directed bench with a queue scoreboard.
// Revision           : 1.0
// ----------------------------------------------------------------------------
module tb_pipe_skid_chain;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n     = 1'b0;
  logic       flush     = 1'b0;
  logic       in_valid  = 1'b0;
  logic [7:0] in_data   = 8'h00;
  logic       out_ready = 1'b0;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic [2:0] occupancy;

  logic        b_flush     = 1'b0;
  logic        b_in_valid  = 1'b0;
  logic [15:0] b_in_data   = 16'h0;
  logic        b_out_ready = 1'b0;
  logic        b_in_ready;
  logic        b_out_valid;
  logic [15:0] b_out_data;
  logic [1:0]  b_occupancy;

  pipe_skid_chain #(.DATA_W(8), .STAGES(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy)
  );

  pipe_skid_chain #(.DATA_W(16), .STAGES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .occupancy(b_occupancy)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: an ideal FIFO of beats that crossed the input handshake.
  logic [7:0] model_q [$];
  bit armed   = 1'b0;
  bit was_rst = 1'b0;

  always @(negedge clk) begin
    logic [7:0] exp_d;
    if (armed) begin
      check("occupancy", 32'(occupancy), 32'(model_q.size()));
      if (was_rst) check("in_ready_after_reset_edge", 32'(in_ready), 0);
      if (model_q.size() == 0) begin
        check("out_valid_when_empty", 32'(out_valid), 0);
      end else if (out_valid && out_ready) begin
        exp_d = model_q.pop_front();
        check("out_data_order", 32'(out_data), 32'(exp_d));
      end
    end
    was_rst = !rst_n;
    if (!rst_n) begin
      model_q.delete();
      armed = 1'b1;
    end else if (flush) begin
      model_q.delete();
    end else if (in_valid && in_ready) begin
      model_q.push_back(in_data);
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] t1 [4];
    logic [7:0] nxt;
    bit fire, seen, seen88;
    int acc, wait_n, guard;

    t1[0] = 8'hA5; t1[1] = 8'h3C; t1[2] = 8'h5A; t1[3] = 8'hC3;

    // Reset both instances
    rst_n = 1'b0;
    tick(); tick();
    check("reset_in_ready", 32'(in_ready), 0);
    check("reset_b_in_ready", 32'(b_in_ready), 0);
    rst_n = 1'b1;
    tick();
    check("release_in_ready", 32'(in_ready), 1);
    check("release_b_in_ready", 32'(b_in_ready), 1);

    // Streaming at full rate, two-hop latency
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = t1[i];
      check("t1_in_ready", 32'(in_ready), 1);
      tick();
      if (i == 0) begin
        check("t1_latency_not_yet", 32'(out_valid), 0);
      end else begin
        check("t1_out_valid", 32'(out_valid), 1);
        check("t1_out_data", 32'(out_data), 32'(t1[i-1]));
      end
    end
    in_valid = 1'b0;
    tick();
    check("t1_last_valid", 32'(out_valid), 1);
    check("t1_last_data", 32'(out_data), 32'hC3);
    tick();
    check("t1_drained", 32'(out_valid), 0);

    // Backpressure: capacity of 2*STAGES
    out_ready = 1'b0;
    nxt = 8'd1; in_data = nxt; in_valid = 1'b1; acc = 0;
    for (int c = 0; c < 10; c++) begin
      fire = in_valid && in_ready;
      tick();
      if (fire) begin
        acc++; nxt++;
        if (nxt <= 8'd6) in_data = nxt; else in_valid = 1'b0;
      end
    end
    check("t2_accepted", 32'(acc), 4);
    check("t2_in_ready_low", 32'(in_ready), 0);
    check("t2_occupancy", 32'(occupancy), 4);
    check("t2_head_valid", 32'(out_valid), 1);
    check("t2_head_data", 32'(out_data), 32'h01);
    out_ready = 1'b1; seen = 1'b0; wait_n = 0;
    for (int c = 0; c < 20; c++) begin
      fire = in_valid && in_ready;
      tick();
      if (fire) begin
        acc++; nxt++;
        if (nxt <= 8'd6) in_data = nxt; else in_valid = 1'b0;
      end
      if (!seen && in_ready) begin seen = 1'b1; wait_n = c + 1; end
    end
    check("t2_all_accepted", 32'(acc), 6);
    check("t2_ready_return", 32'(seen && wait_n <= 2), 1);
    check("t2_empty", 32'(occupancy), 0);

    // Randomized backpressure over 200 beats
    nxt = 8'h00; acc = 0; guard = 0;
    in_valid = 1'b1; in_data = nxt;
    while (acc < 200 && guard < 3000) begin
      fire = in_valid && in_ready;
      tick();
      guard++;
      if (fire) begin acc++; nxt++; end
      if (!in_valid || fire) begin
        in_valid = ($urandom_range(99) < 80);
        in_data  = nxt;
      end
      out_ready = $urandom_range(1);
    end
    check("t3_beats_within_budget", 32'(acc), 200);
    in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 8; c++) tick();
    check("t3_drained", 32'(occupancy), 0);

    // Flush while full, offered beat discarded
    out_ready = 1'b0; nxt = 8'h11; in_data = nxt; in_valid = 1'b1; acc = 0; guard = 0;
    while (acc < 4 && guard < 20) begin
      fire = in_valid && in_ready;
      tick();
      guard++;
      if (fire) begin acc++; nxt++; in_data = nxt; end
    end
    check("t4_filled", 32'(acc), 4);
    flush = 1'b1; in_data = 8'h77; in_valid = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("t4_occ_zero", 32'(occupancy), 0);
    check("t4_out_valid_zero", 32'(out_valid), 0);
    check("t4_in_ready", 32'(in_ready), 1);
    in_data = 8'h88; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0; seen88 = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (out_valid && out_data == 8'h88) seen88 = 1'b1;
      tick();
    end
    check("t4_88_delivered", 32'(seen88), 1);

    // Flush with in_ready high: offered beat still dropped
    out_ready = 1'b0; in_data = 8'h21; in_valid = 1'b1;
    tick();
    check("t4b_in_ready_high", 32'(in_ready), 1);
    flush = 1'b1; in_data = 8'h99;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("t4b_occ_zero", 32'(occupancy), 0);
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) tick();

    // Reset mid-stream drops everything
    out_ready = 1'b0; nxt = 8'h40; in_data = nxt; in_valid = 1'b1; acc = 0; guard = 0;
    while (acc < 3 && guard < 20) begin
      fire = in_valid && in_ready;
      tick();
      guard++;
      if (fire) begin acc++; nxt++; in_data = nxt; end
    end
    in_valid = 1'b0;
    check("t5_occ_three", 32'(occupancy), 3);
    rst_n = 1'b0;
    tick();
    check("t5_rst_out_valid", 32'(out_valid), 0);
    check("t5_rst_occ", 32'(occupancy), 0);
    check("t5_rst_in_ready", 32'(in_ready), 0);
    rst_n = 1'b1;
    tick();
    check("t5_release_in_ready", 32'(in_ready), 1);
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      check("t5_no_stale", 32'(out_valid), 0);
    end

    // Single-stage, 16-bit instance
    b_out_ready = 1'b0; b_in_valid = 1'b1; b_in_data = 16'h1234;
    check("t6_rdy0", 32'(b_in_ready), 1);
    tick();
    check("t6_lat1_valid", 32'(b_out_valid), 1);
    check("t6_lat1_data", 32'(b_out_data), 32'h1234);
    check("t6_rdy1", 32'(b_in_ready), 1);
    b_in_data = 16'hABCD;
    tick();
    b_in_valid = 1'b0;
    check("t6_rdy_low", 32'(b_in_ready), 0);
    check("t6_occ2", 32'(b_occupancy), 2);
    check("t6_hold_data", 32'(b_out_data), 32'h1234);
    b_out_ready = 1'b1;
    tick();
    check("t6_second_valid", 32'(b_out_valid), 1);
    check("t6_second_data", 32'(b_out_data), 32'hABCD);
    check("t6_rdy_back", 32'(b_in_ready), 1);
    check("t6_occ1", 32'(b_occupancy), 1);
    tick();
    check("t6_empty_valid", 32'(b_out_valid), 0);
    check("t6_occ0", 32'(b_occupancy), 0);

    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
